// File: rtl/virtual_point_reader.sv
// Walks every virtual point once per frame: reads its scalars and colour from the provider,
// maps it through the latched tracking points, and hands it downstream over valid/ready.
module virtual_point_reader #(
    parameter int N_TRACKING_POINTS = 4,
    parameter int N_VIRTUAL_POINTS  = 48,
    parameter int READ_LATENCY      = 2
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  frame_start,
    input  logic [N_TRACKING_POINTS-1:0][10:0]    tracking_x,
    input  logic [N_TRACKING_POINTS-1:0][9:0]     tracking_y,
    input  logic [N_TRACKING_POINTS-2:0][15:0]    point_scalars,
    input  logic [3:0]                            point_color,
    output logic                                  next_point,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [10:0]                           out_x,
    output logic [9:0]                            out_y,
    output logic [3:0]                            out_color,
    output logic                                  out_last,
    output logic                                  busy
);

    localparam int TW = $clog2(N_TRACKING_POINTS);
    localparam int IW = (N_VIRTUAL_POINTS > 1) ? $clog2(N_VIRTUAL_POINTS) : 1;
    localparam int CW = 8;

    typedef enum logic [2:0] {IDLE, WAIT, MAC, EMIT, PULSE} state_t;

    state_t                                 state_q;
    logic [CW-1:0]                          cnt_q;
    logic [IW-1:0]                          idx_q;
    logic [N_TRACKING_POINTS-1:0][10:0]     trackX_q;
    logic [N_TRACKING_POINTS-1:0][9:0]      trackY_q;
    logic [N_TRACKING_POINTS-2:0][15:0]     scalars_q;
    logic [3:0]                             color_q;
    logic signed [31:0]                     accX_q;
    logic signed [31:0]                     accY_q;

    logic                                   nextPoint_q;
    logic                                   outValid_q;
    logic [10:0]                            outX_q;
    logic [9:0]                             outY_q;
    logic [3:0]                             outColor_q;
    logic                                   outLast_q;
    logic                                   busy_q;

    logic [TW-1:0]                          scalIdx;
    logic [TW-1:0]                          termIdx;
    logic signed [11:0]                     diffX;
    logic signed [11:0]                     diffY;
    logic signed [27:0]                     scalExt;
    logic signed [27:0]                     prodX;
    logic signed [27:0]                     prodY;
    logic signed [31:0]                     accXNext;
    logic signed [31:0]                     accYNext;
    logic signed [32:0]                     sumX;
    logic signed [32:0]                     sumY;
    logic [10:0]                            clampX;
    logic [9:0]                             clampY;

    // MAC cycle k adds term j = k+1, weighted by scalar k, relative to tracking point 0.
    always_comb begin
        scalIdx  = cnt_q[TW-1:0];
        termIdx  = scalIdx + TW'(1);
        diffX    = signed'({1'b0, trackX_q[termIdx]}) - signed'({1'b0, trackX_q[0]});
        diffY    = signed'({2'b00, trackY_q[termIdx]}) - signed'({2'b00, trackY_q[0]});
        scalExt  = 28'(signed'(scalars_q[scalIdx]));
        prodX    = scalExt * 28'(diffX);
        prodY    = scalExt * 28'(diffY);
        accXNext = accX_q + 32'(prodX);
        accYNext = accY_q + 32'(prodY);
        sumX     = signed'({22'd0, trackX_q[0]}) + 33'(accXNext >>> 14);
        sumY     = signed'({23'd0, trackY_q[0]}) + 33'(accYNext >>> 14);
        clampX   = sumX[10:0];
        if (sumX < 0) begin
            clampX = 11'd0;
        end else if (sumX > 33'sd2047) begin
            clampX = 11'd2047;
        end
        clampY   = sumY[9:0];
        if (sumY < 0) begin
            clampY = 10'd0;
        end else if (sumY > 33'sd1023) begin
            clampY = 10'd1023;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            trackX_q    <= '0;
            trackY_q    <= '0;
            scalars_q   <= '0;
            color_q     <= '0;
            accX_q      <= '0;
            accY_q      <= '0;
            nextPoint_q <= 1'b0;
            outValid_q  <= 1'b0;
            outX_q      <= '0;
            outY_q      <= '0;
            outColor_q  <= '0;
            outLast_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            nextPoint_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        trackX_q <= tracking_x;
                        trackY_q <= tracking_y;
                        idx_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == CW'(READ_LATENCY - 1)) begin
                        scalars_q <= point_scalars;
                        color_q   <= point_color;
                        accX_q    <= '0;
                        accY_q    <= '0;
                        cnt_q     <= '0;
                        state_q   <= MAC;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                MAC: begin
                    accX_q <= accXNext;
                    accY_q <= accYNext;
                    if (cnt_q == CW'(N_TRACKING_POINTS - 2)) begin
                        outX_q     <= clampX;
                        outY_q     <= clampY;
                        outColor_q <= color_q;
                        outLast_q  <= (idx_q == IW'(N_VIRTUAL_POINTS - 1));
                        outValid_q <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= EMIT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        outValid_q  <= 1'b0;
                        nextPoint_q <= 1'b1;
                        state_q     <= PULSE;
                    end
                end
                PULSE: begin
                    // The final pulse wraps the provider back to point 0.
                    outLast_q <= 1'b0;
                    cnt_q     <= '0;
                    if (outLast_q) begin
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= WAIT;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign next_point = nextPoint_q;
    assign out_valid  = outValid_q;
    assign out_x      = outX_q;
    assign out_y      = outY_q;
    assign out_color  = outColor_q;
    assign out_last   = outLast_q;
    assign busy       = busy_q;

endmodule
